// File: rtl/barker_pkg.sv
// Shared constants and state encoding for the Barker-13 chip-stream peak detector.
package barker_pkg;

  localparam int CORR_W = 5;
  localparam int WIN_W  = 13;

  // Oldest chip sits in the MSB, matching the window shift direction.
  localparam logic [WIN_W-1:0] BARKER13 = 13'b1111100110101;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    SEARCH  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/axis_1bit.sv
// 1-bit AXI-Stream bundle shared by the chip-rate blocks.
interface axis_1bit;
  logic tvalid;
  logic tready;
  logic tdata;
  logic tuser;
  logic tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/popcount13.sv
// Combinational count of set bits in a 13-bit word.
module popcount13 (
  input  logic [12:0] din,
  output logic [3:0]  ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < 13; i++) begin
      ones = ones + 4'(din[i]);
    end
  end

endmodule

// File: rtl/axis_barker_detect.sv
// Barker-13 correlator on a 1-bit AXI-Stream chip stream; flags |correlation| peaks
// with polarity, one output beat per accepted input beat, two-stage pipeline.
module axis_barker_detect
  import barker_pkg::state_e;
#(
  parameter int THRESHOLD = 11,
  parameter int HOLDOFF   = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  axis_1bit.slave                 s_axis,
  axis_1bit.master                m_axis,
  output logic signed [4:0]       o_corr,
  output logic [15:0]             o_peak_cnt,
  output state_e                  o_state
);

  import barker_pkg::BARKER13;
  import barker_pkg::CORR_W;
  import barker_pkg::FILL;
  import barker_pkg::SEARCH;

  localparam int TW = CORR_W + 1;
  localparam logic signed [TW-1:0] TH_POS = TW'(THRESHOLD);
  localparam logic signed [TW-1:0] TH_NEG = -TH_POS;
  localparam logic [3:0] FILL_LAST = 4'd12;
  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);
  localparam bit HAS_HOLDOFF = (HOLDOFF != 0);

  // Handshake: a beat transfers on a rising edge where tvalid && tready. Both stages
  // advance together when the output register is empty or being drained (en), and
  // s_axis.tready is exactly en, so a stalled output freezes the whole pipe.
  logic en;
  logic accept;
  assign en            = !m_axis.tvalid || m_axis.tready;
  assign s_axis.tready = en;
  assign accept        = s_axis.tvalid && en;

  logic unused_tuser;
  assign unused_tuser = s_axis.tuser;

  // Stage 1: window shift and correlation register.
  logic [12:0]       win_q;
  logic [12:0]       win_next;
  logic [3:0]        mism;
  logic signed [4:0] corr_q;
  logic signed [4:0] corr_next;
  logic              s1_valid_q;
  logic              s1_last_q;

  assign win_next  = {win_q[11:0], s_axis.tdata};
  assign corr_next = 5'd13 - {mism, 1'b0};

  popcount13 u_popcount (
    .din  (win_next ^ BARKER13),
    .ones (mism)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q      <= '0;
      corr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && s_axis.tlast;
      if (accept) begin
        win_q  <= s_axis.tlast ? '0 : win_next;
        corr_q <= corr_next;
      end
    end
  end

  // Stage 2: frame state machine consumes each stage-1 beat as it moves to the output.
  state_e            state_q, state_d;
  logic [3:0]        fill_q, fill_d;
  logic [3:0]        hold_q, hold_d;
  logic signed [TW-1:0] corr_ext;
  logic              hit_pos, hit_neg, hit;
  logic              adv;
  logic              peak;
  logic              pol;

  assign corr_ext = TW'(corr_q);
  assign hit_pos  = corr_ext >= TH_POS;
  assign hit_neg  = corr_ext <= TH_NEG;
  assign hit      = hit_pos || hit_neg;
  assign adv      = en && s1_valid_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    peak    = 1'b0;
    pol     = 1'b0;
    if (adv) begin
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + 4'd1;
          // The chip that completes the window is already judged like a SEARCH chip.
          if (fill_q == FILL_LAST) begin
            peak    = hit;
            pol     = hit_neg;
            hold_d  = '0;
            state_d = (hit && HAS_HOLDOFF) ? barker_pkg::HOLDOFF : SEARCH;
          end
        end
        SEARCH: begin
          peak = hit;
          pol  = hit_neg;
          if (hit && HAS_HOLDOFF) begin
            hold_d  = '0;
            state_d = barker_pkg::HOLDOFF;
          end
        end
        barker_pkg::HOLDOFF: begin
          hold_d = hold_q + 4'd1;
          if (hold_q == HOLD_LAST) state_d = SEARCH;
        end
        default: state_d = FILL;
      endcase
      if (s1_last_q) begin
        state_d = FILL;
        fill_d  = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      m_axis.tlast  <= 1'b0;
      o_peak_cnt    <= '0;
    end else if (en) begin
      m_axis.tvalid <= s1_valid_q;
      m_axis.tdata  <= peak;
      m_axis.tuser  <= peak && pol;
      m_axis.tlast  <= s1_last_q;
      if (peak && (o_peak_cnt != 16'hFFFF)) o_peak_cnt <= o_peak_cnt + 16'd1;
    end
  end

  assign o_corr  = corr_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_axis_barker_detect.sv
// Randomised bench for axis_barker_detect against a chip-history reference model.
module tb_axis_barker_detect;
  import barker_pkg::*;

  localparam int TB_THRESHOLD = 11;
  localparam int TB_HOLDOFF   = 12;
  localparam logic [12:0] CODE = 13'b1111100110101;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axis_1bit s_axis ();
  axis_1bit m_axis ();
  logic signed [4:0] o_corr;
  logic [15:0]       o_peak_cnt;
  state_e            o_state;

  axis_barker_detect #(
    .THRESHOLD (TB_THRESHOLD),
    .HOLDOFF   (TB_HOLDOFF)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .s_axis     (s_axis),
    .m_axis     (m_axis),
    .o_corr     (o_corr),
    .o_peak_cnt (o_peak_cnt),
    .o_state    (o_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: chip history of the current frame, correlation by +/-1 sums.
  logic [2:0] exp_q[$];
  bit         frame_q[$];
  int         frame_len, suppress_left, mdl_corr, mdl_peaks, obs_peaks;
  int         cyc, first_acc, first_out, last_out;
  logic [2:0] last_beat;
  logic [2:0] prev_beat;
  bit         stalled;
  bit         rand_ready = 1'b0;

  task automatic mdl_accept(input bit chip, input bit last);
    logic [12:0] code_v;
    int corr, idx;
    bit c, pk, pol;
    code_v = CODE;
    frame_q.push_back(chip);
    if (frame_q.size() > 13) void'(frame_q.pop_front());
    frame_len++;
    corr = 0;
    for (int k = 0; k < 13; k++) begin
      idx  = k - (13 - frame_q.size());
      c    = (idx >= 0) ? frame_q[idx] : 1'b0;
      corr = corr + ((c == code_v[12-k]) ? 1 : -1);
    end
    pk  = 1'b0;
    pol = 1'b0;
    if (frame_len >= 13) begin
      if (suppress_left > 0) suppress_left--;
      else if (corr >= TB_THRESHOLD || corr <= -TB_THRESHOLD) begin
        pk = 1'b1;
        pol = (corr < 0);
        suppress_left = TB_HOLDOFF;
        mdl_peaks++;
      end
    end
    exp_q.push_back({pk, pol, last});
    mdl_corr = corr;
    if (last) begin
      frame_q.delete();
      frame_len = 0;
      suppress_left = 0;
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [2:0] cur;
    cyc++;
    cur = {m_axis.tdata, m_axis.tuser, m_axis.tlast};
    if (!rst_n) begin
      exp_q.delete();
      frame_q.delete();
      frame_len = 0; suppress_left = 0; mdl_corr = 0; mdl_peaks = 0; obs_peaks = 0;
      first_acc = -1; first_out = -1; last_out = -1;
      stalled = 1'b0;
      last_beat = '0;
    end else begin
      check_eq("o_corr", o_corr, mdl_corr);
      if (stalled)
        check_eq("hold_stable", {m_axis.tvalid, cur}, {1'b1, prev_beat});
      if (m_axis.tvalid && m_axis.tready) begin
        check_eq("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("out_beat", cur, exp_q.pop_front());
        last_beat = cur;
        if (m_axis.tdata) obs_peaks++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      stalled   = m_axis.tvalid && !m_axis.tready;
      prev_beat = cur;
      if (s_axis.tvalid && s_axis.tready) begin
        if (first_acc < 0) first_acc = cyc;
        mdl_accept(s_axis.tdata, s_axis.tlast);
      end
    end
  end

  // Output-side ready driver.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Driver tasks
  task automatic send_chip(input bit chip, input bit last);
    int n = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = chip;
    s_axis.tlast  = last;
    s_axis.tuser  = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!s_axis.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("accept_timeout", int'(s_axis.tready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [12:0] word, input bit last_on_end);
    for (int i = 12; i >= 0; i--) send_chip(word[i], last_on_end && (i == 0));
  endtask

  task automatic idle(input int n);
    s_axis.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    s_axis.tvalid = 1'b0;
    while ((exp_q.size() != 0 || m_axis.tvalid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_done", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    s_axis.tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_tvalid", m_axis.tvalid, 0);
    check_eq("rst_out", {m_axis.tdata, m_axis.tuser, m_axis.tlast}, 0);
    check_eq("rst_corr", o_corr, 0);
    check_eq("rst_peak_cnt", o_peak_cnt, 0);
    check_eq("rst_tready", s_axis.tready, 1);
    check_eq("rst_state", int'(o_state), int'(FILL));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [12:0] code_v;
    code_v = CODE;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    #1;
    apply_reset();

    // Clean code, full-rate output
    send_code(CODE, 1'b0);
    drain();
    check_eq("code_last_beat", last_beat, 3'b100);
    check_eq("code_corr", o_corr, 13);
    check_eq("code_peak_cnt", o_peak_cnt, 1);
    check_eq("code_obs_peaks", obs_peaks, 1);
    check_eq("latency", first_out - first_acc, 2);
    check_eq("throughput", last_out - first_out, 12);

    // Inverted code
    apply_reset();
    send_code(~CODE, 1'b0);
    drain();
    check_eq("inv_last_beat", last_beat, 3'b110);
    check_eq("inv_corr", o_corr, -13);

    // One and two chip errors against the default threshold
    apply_reset();
    send_code(CODE ^ 13'h1000, 1'b0);
    drain();
    check_eq("flip1_corr", o_corr, 11);
    check_eq("flip1_last_beat", last_beat, 3'b100);
    apply_reset();
    send_code(CODE ^ 13'h1001, 1'b0);
    drain();
    check_eq("flip2_corr", o_corr, 9);
    check_eq("flip2_obs_peaks", obs_peaks, 0);

    // Back-to-back codes through the holdoff window
    apply_reset();
    send_code(CODE, 1'b0);
    send_code(CODE, 1'b0);
    drain();
    check_eq("b2b_obs_peaks", obs_peaks, 2);
    check_eq("b2b_peak_cnt", o_peak_cnt, 2);
    check_eq("b2b_last_beat", last_beat, 3'b100);

    // Random output backpressure
    apply_reset();
    rand_ready = 1'b1;
    send_code(CODE, 1'b0);
    drain();
    rand_ready = 1'b0;
    check_eq("bp_obs_peaks", obs_peaks, 1);
    check_eq("bp_peak_cnt", o_peak_cnt, 1);
    check_eq("bp_last_beat", last_beat, 3'b100);

    // Short frame ended by tlast, then a full code
    apply_reset();
    for (int i = 0; i < 7; i++) send_chip(1'($urandom_range(0, 1)), i == 6);
    send_code(CODE, 1'b0);
    drain();
    check_eq("tlast_obs_peaks", obs_peaks, 1);
    check_eq("tlast_last_beat", last_beat, 3'b100);

    // Reset in the middle of a code
    apply_reset();
    for (int i = 12; i >= 9; i--) send_chip(code_v[i], 1'b0);
    apply_reset();
    for (int i = 8; i >= 0; i--) send_chip(code_v[i], 1'b0);
    drain();
    check_eq("midrst_obs_peaks", obs_peaks, 0);
    check_eq("midrst_peak_cnt", o_peak_cnt, 0);

    // Random soak: noise, embedded codes, random tlast, gaps and backpressure
    apply_reset();
    rand_ready = 1'b1;
    for (int seg = 0; seg < 50; seg++) begin
      if ($urandom_range(0, 9) < 4) begin
        send_code($urandom_range(0, 1) ? CODE : ~CODE, $urandom_range(0, 7) == 0);
      end else begin
        int len = $urandom_range(1, 20);
        for (int i = 0; i < len; i++) begin
          send_chip(1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
      end
    end
    drain();
    rand_ready = 1'b0;
    check_eq("soak_peak_cnt", o_peak_cnt, mdl_peaks);
    check_eq("soak_obs_peaks", obs_peaks, mdl_peaks);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
